// File: rtl/toy_pack.sv
// rtl/toy_pack.sv - shared widths, types and helpers for the fetch-engine update scheduler
package toy_pack;

    localparam int FE_UPD_IDX_W = 10;
    localparam int FE_UPD_TAG_W = 8;

    typedef struct packed {
        logic                    valid;
        logic [FE_UPD_TAG_W-1:0] tag;
        logic [1:0]              ctr;
    } fe_upd_entry_t;

    localparam int FE_UPD_DATA_W = $bits(fe_upd_entry_t);

    typedef struct packed {
        logic taken;
    } fe_bypass_t;

    typedef struct packed {
        logic [31:0] pc;
        fe_bypass_t  bypass;
        logic        taken_err;
    } fe_upd_pld_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_UPD_WR = 1'b1;

    // Two-bit saturating counter step; bounds are 0 and 3.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        res = ctr;
        if (up && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!up && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/toy_fe_upd_ctr_calc.sv
// rtl/toy_fe_upd_ctr_calc.sv - combinational next-entry computation for a committed branch
module toy_fe_upd_ctr_calc
    import toy_pack::*;
#(
    parameter int IDX_W  = FE_UPD_IDX_W,
    parameter int TAG_W  = FE_UPD_TAG_W,
    parameter int DATA_W = 1 + TAG_W + 2
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [31:0]       pc,
    input  logic              taken,
    input  logic              taken_err,
    output logic [DATA_W-1:0] wdata
);

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [1:0]       rd_ctr;
    logic [TAG_W-1:0] pc_tag;
    logic             hit;
    logic [1:0]       new_ctr;

    assign rd_valid = rdata[DATA_W-1];
    assign rd_tag   = rdata[DATA_W-2:2];
    assign rd_ctr   = rdata[1:0];
    assign pc_tag   = pc[IDX_W+TAG_W+1:IDX_W+2];
    assign hit      = rd_valid && (rd_tag == pc_tag);

    // A mispredict or a miss re-allocates with a weak counter in the taken direction.
    always_comb begin
        new_ctr = ctr_step(rd_ctr, taken);
        if (taken_err || !hit) begin
            new_ctr = taken ? 2'b10 : 2'b01;
        end
    end

    assign wdata = {1'b1, pc_tag, new_ctr};

endmodule

// File: rtl/toy_fe_upd_sched.sv
// rtl/toy_fe_upd_sched.sv - arbitrates commit updates and fetch lookups onto one single-port table SRAM
module toy_fe_upd_sched
    import toy_pack::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int IDX_W        = FE_UPD_IDX_W,
    parameter int TAG_W        = FE_UPD_TAG_W,
    parameter int DATA_W       = 1 + TAG_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_vld,
    output logic              upd_rdy,
    input  fe_upd_pld_t       upd_pld,
    input  logic              upd_cancel_pend,
    input  logic              lkp_vld,
    output logic              lkp_rdy,
    input  logic [IDX_W-1:0]  lkp_idx,
    output logic              lkp_rsp_vld,
    output logic [DATA_W-1:0] lkp_rsp_data,
    output logic              sram_en,
    output logic              sram_we,
    output logic [IDX_W-1:0]  sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rsp_vld_q, rsp_vld_d;
    fe_upd_pld_t      pld_q, pld_d;

    logic              idle;
    logic              upd_win;
    logic              lkp_win;
    logic              upd_issue;
    logic              live;
    logic [IDX_W-1:0]  upd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] calc_wdata;

    assign idle      = (state_q == ST_IDLE);
    assign upd_win   = idle && upd_vld && (!lkp_vld || starve_q == LIMIT);
    assign lkp_win   = idle && lkp_vld && !upd_win;
    assign upd_issue = upd_win && !upd_cancel_pend;
    assign upd_idx   = upd_pld.pc[IDX_W+1:2];
    assign wr_idx    = pld_q.pc[IDX_W+1:2];

    // Every output is forced low while reset is held, which also kills an in-flight write.
    assign live = !rst;

    toy_fe_upd_ctr_calc #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_ctr_calc (
        .rdata     (sram_rdata),
        .pc        (pld_q.pc),
        .taken     (pld_q.bypass.taken),
        .taken_err (pld_q.taken_err),
        .wdata     (calc_wdata)
    );

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        pld_d     = pld_q;
        rsp_vld_d = lkp_win;
        if (idle) begin
            if (upd_win) begin
                starve_d = '0;
                pld_d    = upd_pld;
                if (upd_issue) begin
                    state_d = ST_UPD_WR;
                end
            end else if (lkp_win && upd_vld && starve_q != LIMIT) begin
                starve_d = starve_q + 1'b1;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        upd_rdy    = 1'b0;
        lkp_rdy    = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (live) begin
            if (idle) begin
                upd_rdy = upd_win;
                lkp_rdy = lkp_win;
                if (upd_issue) begin
                    sram_en   = 1'b1;
                    sram_addr = upd_idx;
                end else if (lkp_win) begin
                    sram_en   = 1'b1;
                    sram_addr = lkp_idx;
                end
            end else begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = wr_idx;
                sram_wdata = calc_wdata;
            end
        end
    end

    assign lkp_rsp_vld  = rsp_vld_q;
    assign lkp_rsp_data = rsp_vld_q ? sram_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            starve_q  <= '0;
            rsp_vld_q <= 1'b0;
            pld_q     <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            rsp_vld_q <= rsp_vld_d;
            pld_q     <= pld_d;
        end
    end

endmodule

// File: tb/tb_toy_fe_upd_sched.sv
// tb/tb_toy_fe_upd_sched.sv - directed self-checking bench for toy_fe_upd_sched
module tb_toy_fe_upd_sched;
    import toy_pack::*;

    logic        clk;
    logic        rst;
    logic        upd_vld;
    logic        upd_rdy;
    fe_upd_pld_t upd_pld;
    logic        upd_cancel_pend;
    logic        lkp_vld;
    logic        lkp_rdy;
    logic [9:0]  lkp_idx;
    logic        lkp_rsp_vld;
    logic [10:0] lkp_rsp_data;
    logic        sram_en;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [10:0] sram_wdata;
    logic [10:0] sram_rdata;

    logic [10:0] mem [0:1023];
    int n_checks;
    int n_errors;

    toy_fe_upd_sched dut (
        .clk             (clk),
        .rst             (rst),
        .upd_vld         (upd_vld),
        .upd_rdy         (upd_rdy),
        .upd_pld         (upd_pld),
        .upd_cancel_pend (upd_cancel_pend),
        .lkp_vld         (lkp_vld),
        .lkp_rdy         (lkp_rdy),
        .lkp_idx         (lkp_idx),
        .lkp_rsp_vld     (lkp_rsp_vld),
        .lkp_rsp_data    (lkp_rsp_data),
        .sram_en         (sram_en),
        .sram_we         (sram_we),
        .sram_addr       (sram_addr),
        .sram_wdata      (sram_wdata),
        .sram_rdata      (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full two-cycle update; the payload is scrambled during the write cycle.
    task automatic upd_op(input logic [31:0] pc, input logic tk, input logic err,
                          input logic [9:0] exp_addr, input logic [10:0] exp_wd, input string tag);
        upd_vld = 1'b1;
        upd_cancel_pend = 1'b0;
        upd_pld.pc = pc;
        upd_pld.bypass.taken = tk;
        upd_pld.taken_err = err;
        #1;
        chk({tag, "_rdy"}, {31'd0, upd_rdy}, 32'd1);
        chk({tag, "_rd"}, {20'd0, sram_en, sram_we, sram_addr}, {20'd0, 1'b1, 1'b0, exp_addr});
        tick;
        upd_pld.pc = 32'hFFFF_FFFC;
        upd_pld.bypass.taken = ~tk;
        upd_pld.taken_err = ~err;
        #1;
        chk({tag, "_wr_rdy"}, {31'd0, upd_rdy}, 32'd0);
        chk({tag, "_wr"}, {20'd0, sram_en, sram_we, sram_addr}, {20'd0, 1'b1, 1'b1, exp_addr});
        chk({tag, "_wdata"}, {21'd0, sram_wdata}, {21'd0, exp_wd});
        tick;
        upd_vld = 1'b0;
    endtask

    initial begin
        logic [1:0] sat_seq [0:7];
        sat_seq = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        sram_rdata = '0;
        rst = 1'b1;
        upd_vld = 1'b1;
        lkp_vld = 1'b1;
        lkp_idx = 10'd3;
        upd_cancel_pend = 1'b0;
        upd_pld = '0;
        #12;
        chk("rst_outs", {27'd0, upd_rdy, lkp_rdy, sram_en, sram_we, lkp_rsp_vld}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        upd_vld = 1'b0;
        lkp_vld = 1'b0;
        tick;
        chk("post_rst_rsp", {31'd0, lkp_rsp_vld}, 32'd0);

        upd_op(32'h0000_1000, 1'b1, 1'b0, 10'h000, 11'h406, "miss_alloc");

        for (int i = 0; i < 8; i++) begin
            upd_op(32'h0000_2004, (i < 4), 1'b0, 10'h001, 11'h408 | {9'd0, sat_seq[i]}, $sformatf("sat%0d", i));
        end

        upd_op(32'h0000_2004, 1'b0, 1'b1, 10'h001, 11'h409, "taken_err");

        lkp_vld = 1'b1;
        lkp_idx = 10'h001;
        upd_vld = 1'b1;
        upd_pld.pc = 32'h0000_3008;
        upd_pld.bypass.taken = 1'b1;
        upd_pld.taken_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("starve_lkp%0d", i), {30'd0, lkp_rdy, upd_rdy}, 32'd2);
            if (i > 0) chk($sformatf("starve_rsp%0d", i), {20'd0, lkp_rsp_vld, lkp_rsp_data}, {20'd0, 1'b1, 11'h409});
            tick;
        end
        #1;
        chk("starve_grant", {19'd0, upd_rdy, lkp_rdy, sram_we, sram_addr}, {19'd0, 1'b1, 1'b0, 1'b0, 10'h002});
        chk("starve_rsp4", {20'd0, lkp_rsp_vld, lkp_rsp_data}, {20'd0, 1'b1, 11'h409});
        tick;
        #1;
        chk("starve_wr", {30'd0, lkp_rdy, sram_we}, 32'd1);
        chk("starve_wdata", {21'd0, sram_wdata}, 32'h40E);
        chk("starve_wr_rsp", {31'd0, lkp_rsp_vld}, 32'd0);
        tick;
        #1;
        chk("starve_cleared", {30'd0, lkp_rdy, upd_rdy}, 32'd2);
        lkp_vld = 1'b0;
        upd_vld = 1'b0;
        tick;

        upd_vld = 1'b1;
        upd_cancel_pend = 1'b1;
        upd_pld.pc = 32'h0000_4010;
        #1;
        chk("cancel", {30'd0, upd_rdy, sram_en}, 32'd2);
        tick;
        upd_op(32'h0000_4010, 1'b1, 1'b0, 10'h004, 11'h412, "after_cancel");

        upd_op(32'h0000_0040, 1'b0, 1'b0, 10'h010, 11'h401, "raw_upd");
        lkp_vld = 1'b1;
        lkp_idx = 10'h010;
        #1;
        chk("raw_lkp", {21'd0, lkp_rdy, sram_addr}, {21'd0, 1'b1, 10'h010});
        tick;
        lkp_vld = 1'b0;
        #1;
        chk("raw_rsp", {20'd0, lkp_rsp_vld, lkp_rsp_data}, {20'd0, 1'b1, 11'h401});
        tick;

        upd_vld = 1'b1;
        upd_cancel_pend = 1'b0;
        upd_pld.pc = 32'h0000_5014;
        upd_pld.bypass.taken = 1'b1;
        upd_pld.taken_err = 1'b0;
        #1;
        chk("rstmid_grant", {31'd0, upd_rdy}, 32'd1);
        tick;
        upd_vld = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_outs", {29'd0, sram_en, sram_we, upd_rdy}, 32'd0);
        chk("rstmid_wdata", {21'd0, sram_wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick;
        lkp_vld = 1'b1;
        lkp_idx = 10'h005;
        #1;
        chk("rstmid_lkp", {31'd0, lkp_rdy}, 32'd1);
        tick;
        lkp_vld = 1'b0;
        #1;
        chk("rstmid_entry", {20'd0, lkp_rsp_vld, lkp_rsp_data}, {20'd0, 1'b1, 11'h000});
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
